// File: rtl/axi4_pkg.sv
// rtl/axi4_pkg.sv - AXI4 channel structs shared by the master and its interconnect.
package axi4_pkg;
    localparam int ID_W = 4;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     addr;
        logic [7:0]      len;
        logic [2:0]      size;
        logic [1:0]      burst;
        logic            valid;
    } ax_m_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
        logic        valid;
    } w_m_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
        logic            valid;
    } b_s_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [31:0]     data;
        logic [1:0]      resp;
        logic            last;
        logic            valid;
    } r_s_t;

    typedef struct packed {
        logic ready;
    } ready_t;
endpackage

// File: rtl/riscv_axi_master_pkg.sv
// rtl/riscv_axi_master_pkg.sv - Pending-table entry type and fixed AXI field values.
package riscv_axi_master_pkg;
    localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef struct packed {
        logic        live;
        logic        rnw;
        logic [31:0] addr;
        logic        done;
        logic        err;
        logic [31:0] data;
    } pending_entry_t;
endpackage

// File: rtl/riscv_axi_pending_table.sv
// rtl/riscv_axi_pending_table.sv - Circular outstanding-transaction table indexed by AXI ID.
module riscv_axi_pending_table
    import riscv_axi_master_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             alloc,
    input  logic             alloc_rnw,
    input  logic [31:0]      alloc_addr,
    output logic [PTR_W-1:0] wr_ptr,
    input  logic             cap_a_vld,
    input  logic [PTR_W-1:0] cap_a_id,
    input  logic [31:0]      cap_a_data,
    input  logic             cap_a_err,
    output logic             cap_a_ok,
    input  logic             cap_b_vld,
    input  logic [PTR_W-1:0] cap_b_id,
    input  logic [31:0]      cap_b_data,
    input  logic             cap_b_err,
    output logic             cap_b_ok,
    input  logic             retire,
    output pending_entry_t   head,
    output logic [PTR_W:0]   count
);
    pending_entry_t entries [DEPTH];
    logic [PTR_W-1:0] rd_ptr;

    // A second capture to the same ID in one cycle loses and is reported as unexpected.
    assign cap_a_ok = cap_a_vld & entries[cap_a_id].live & ~entries[cap_a_id].done;
    assign cap_b_ok = cap_b_vld & entries[cap_b_id].live & ~entries[cap_b_id].done
                    & ~(cap_a_ok & (cap_a_id == cap_b_id));
    assign head = entries[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (alloc) begin
                entries[wr_ptr] <= '{live: 1'b1, rnw: alloc_rnw, addr: alloc_addr,
                                     done: 1'b0, err: 1'b0, data: 32'h0};
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (cap_a_ok) begin
                entries[cap_a_id].done <= 1'b1;
                entries[cap_a_id].data <= cap_a_data;
                entries[cap_a_id].err  <= cap_a_err;
            end
            if (cap_b_ok) begin
                entries[cap_b_id].done <= 1'b1;
                entries[cap_b_id].data <= cap_b_data;
                entries[cap_b_id].err  <= cap_b_err;
            end
            if (retire) begin
                entries[rd_ptr].live <= 1'b0;
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (alloc && !retire)      count <= count + (PTR_W+1)'(1);
            else if (!alloc && retire) count <= count - (PTR_W+1)'(1);
        end
    end
endmodule

// File: rtl/riscv_axi_master.sv
// rtl/riscv_axi_master.sv - CPU request stream to single-beat AXI4 with in-order responses.
module riscv_axi_master
    import axi4_pkg::*;
    import riscv_axi_master_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_vld,
    input  logic             req_rnw,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_data,
    input  logic [3:0]       req_strb,
    output logic             req_ack,
    output logic             rsp_vld,
    input  logic             rsp_rdy,
    output logic             rsp_rnw,
    output logic [31:0]      rsp_addr,
    output logic [31:0]      rsp_data,
    output logic             rsp_err,
    output logic             unexp_rsp,
    output logic [PTR_W:0]   pending_cnt,
    input  ready_t           AXI_AW_S,
    input  ready_t           AXI_W_S,
    input  b_s_t             AXI_B_S,
    input  ready_t           AXI_AR_S,
    input  r_s_t             AXI_R_S,
    output ax_m_t            AXI_AW_M,
    output w_m_t             AXI_W_M,
    output ready_t           AXI_B_M,
    output ax_m_t            AXI_AR_M,
    output ready_t           AXI_R_M
);
    logic aw_done, w_done;
    logic full, can_issue, is_wr, ar_hs, aw_hs, w_hs, wr_ack, retire;
    logic r_id_ok, b_id_ok, r_ok, b_ok;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0] count;
    pending_entry_t head;
    logic unused_r_last;

    assign unused_r_last = AXI_R_S.last;

    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign can_issue = req_vld & ~full & ~reset;
    assign is_wr     = can_issue & ~req_rnw;
    assign ar_hs     = can_issue & req_rnw & AXI_AR_S.ready;
    assign aw_hs     = is_wr & ~aw_done & AXI_AW_S.ready;
    assign w_hs      = is_wr & ~w_done & AXI_W_S.ready;
    // A write is accepted once both AW and W have handshaken, in either order.
    assign wr_ack    = is_wr & (aw_done | aw_hs) & (w_done | w_hs);
    assign req_ack   = ar_hs | wr_ack;

    always_comb begin
        AXI_AR_M       = '0;
        AXI_AR_M.valid = can_issue & req_rnw;
        AXI_AR_M.id    = ID_W'(wr_ptr);
        AXI_AR_M.addr  = req_addr;
        AXI_AR_M.size  = AXI_SIZE_WORD;
        AXI_AR_M.burst = AXI_BURST_INCR;
        AXI_AW_M       = AXI_AR_M;
        AXI_AW_M.valid = is_wr & ~aw_done;
        AXI_W_M.valid  = is_wr & ~w_done;
        AXI_W_M.data   = req_data;
        AXI_W_M.strb   = req_strb;
        AXI_W_M.last   = 1'b1;
        AXI_B_M.ready  = 1'b1;
        AXI_R_M.ready  = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if (wr_ack) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
        end
    end

    // IDs beyond the table are never issued, so they can only be stale or bogus.
    assign r_id_ok = ({1'b0, AXI_R_S.id} < (ID_W+1)'(DEPTH));
    assign b_id_ok = ({1'b0, AXI_B_S.id} < (ID_W+1)'(DEPTH));

    always_ff @(posedge clock) begin
        if (reset)
            unexp_rsp <= 1'b0;
        else if ((AXI_R_S.valid && !r_ok) || (AXI_B_S.valid && !b_ok))
            unexp_rsp <= 1'b1;
    end

    assign retire      = rsp_vld & rsp_rdy;
    assign rsp_vld     = head.live & head.done;
    assign rsp_rnw     = head.rnw;
    assign rsp_addr    = head.addr;
    assign rsp_data    = head.data;
    assign rsp_err     = head.err;
    assign pending_cnt = count;

    riscv_axi_pending_table #(.DEPTH(DEPTH)) u_table (
        .clock      (clock),
        .reset      (reset),
        .alloc      (req_ack),
        .alloc_rnw  (req_rnw),
        .alloc_addr (req_addr),
        .wr_ptr     (wr_ptr),
        .cap_a_vld  (AXI_R_S.valid & r_id_ok),
        .cap_a_id   (AXI_R_S.id[PTR_W-1:0]),
        .cap_a_data (AXI_R_S.data),
        .cap_a_err  (AXI_R_S.resp != AXI_RESP_OKAY),
        .cap_a_ok   (r_ok),
        .cap_b_vld  (AXI_B_S.valid & b_id_ok),
        .cap_b_id   (AXI_B_S.id[PTR_W-1:0]),
        .cap_b_data (32'h0),
        .cap_b_err  (AXI_B_S.resp != AXI_RESP_OKAY),
        .cap_b_ok   (b_ok),
        .retire     (retire),
        .head       (head),
        .count      (count)
    );
endmodule

// File: doc/riscv_axi_master.md
Name: riscv_axi_master

Overview:
- Parametrised successor to the single-channel CPU-side AXI4 driver.
- Converts a valid/ack CPU request stream into single-beat AXI4 reads (AR/R) and writes (AW/W/B).
- Tracks up to DEPTH outstanding transactions in a circular table indexed by AXI ID.
- Returns responses in request order through a valid/ready port that carries an error flag.
- Sits between the RISC-V core's load/store/fetch logic and the system AXI interconnect.

Parameters:
- DEPTH, 8: outstanding-transaction table entries; power of 2, range 2..16; also the number of AXI IDs used.
- PTR_W, $clog2(DEPTH): table index width, derived; IDs occupy ID[PTR_W-1:0], upper ID bits are 0.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_vld  in  1  request valid; requester holds it and the fields stable until req_ack.
- req_rnw  in  1  1 = read, 0 = write.
- req_addr  in  32  byte address.
- req_data  in  32  write data.
- req_strb  in  4  write byte strobes.
- req_ack  out  1  request accepted this cycle.
- rsp_vld  out  1  in-order response valid.
- rsp_rdy  in  1  consumer ready.
- rsp_rnw  out  1  response type.
- rsp_addr  out  32  address of the original request.
- rsp_data  out  32  read data; 0 for writes.
- rsp_err  out  1  RRESP/BRESP was not OKAY.
- unexp_rsp  out  1  sticky; set on an R or B response whose ID has no live entry.
- pending_cnt  out  PTR_W+1  live entries.
- AXI_AW_S, AXI_W_S, AXI_B_S, AXI_AR_S, AXI_R_S  in  axi4_pkg structs.
- AXI_AW_M, AXI_W_M, AXI_B_M, AXI_AR_M, AXI_R_M  out  axi4_pkg structs.

Behaviour:
- Reset (synchronous, active-high):
  - Clears the table, wr_ptr, rd_ptr, count, aw_done, w_done and unexp_rsp.
  - All outputs read 0; rsp_data/rsp_addr are 0, never X.
  - Responses to transactions issued before reset arrive at dead entries: dropped, unexp_rsp set.
- full = (count == DEPTH).
- Fixed AXI fields on every transaction:
  - LEN = 0, SIZE = 3'b010, BURST = INCR, WLAST = 1.
  - ARID/AWID = wr_ptr.
  - RREADY = BREADY = 1 always; space is reserved at issue.
- Read issue:
  - ARVALID = req_vld & req_rnw & ~full. VALID never depends on READY.
  - req_ack = ARVALID & ARREADY. Zero-cycle latency from request to AR.
- Write issue:
  - AWVALID = req_vld & ~req_rnw & ~full & ~aw_done.
  - WVALID = req_vld & ~req_rnw & ~full & ~w_done.
  - aw_done / w_done set on the respective handshake when the other channel has not yet completed.
  - req_ack in the cycle the last outstanding of the two handshakes completes; the same cycle if both complete together.
  - aw_done and w_done clear on req_ack.
  - W carries WDATA = req_data, WSTRB = req_strb.
- Allocation on req_ack:
  - entry[wr_ptr] = {live=1, rnw, addr, done=0}; wr_ptr increments modulo DEPTH.
- Capture:
  - On RVALID: if entry[RID] is live and not done, set done, store data, err = (RRESP != OKAY).
  - On BVALID: the same, using BID, with data = 0.
  - Otherwise the response is dropped and unexp_rsp is set.
  - R and B captures in the same cycle to different IDs are both taken.
- Export:
  - rsp_vld = entry[rd_ptr].live & done.
  - On rsp_vld & rsp_rdy: clear live, increment rd_ptr. rsp_* fields are held stable while stalled.
  - Export latency is at least 1 cycle after capture; no bypass.
- Count:
  - +1 on alloc, -1 on retire; both in one cycle leaves it unchanged.
  - DEPTH-1 → DEPTH on alloc blocks the next request.
  - Pointer wrap DEPTH-1 → 0 is seamless.
- Out-of-order AXI responses are reordered; only rd_ptr retires.

Decomposition:
- Package riscv_axi_master_pkg:
  - pending_entry_t {live, rnw, addr[31:0], done, err, data[31:0]}.
  - Constants AXI_SIZE_WORD, AXI_BURST_INCR, AXI_RESP_OKAY.
- Sub-module riscv_axi_pending_table (DEPTH):
  - Holds entries, pointers and count.
  - Ports: alloc, capture (×2), retire.
- The top level holds the AR/AW/W issue logic and the done flags.

Test Plan:
- Read 0x1000 with ARREADY=1 → same-cycle ack, ARID=0. R with RDATA=0xDEADBEEF, RID=0 → next cycle rsp_vld, data=0xDEADBEEF, err=0.
- Write 0x2000, data 0x55AA, strb=0xF. AWREADY=1 in cycle 0, WREADY=1 only in cycle 3 → AW once, ack in cycle 3. BRESP=SLVERR → rsp_err=1, rsp_data=0.
- DEPTH=8, 8 reads, no responses → 9th request ARVALID=0, pending_cnt=8. One response and retire → issue resumes with ARID=0 (wrap).
- Reads with IDs 0,1,2; R arrives as 2,0,1 → rsp_addr returned in order 0,1,2. rsp_rdy=0 for 3 cycles holds the first response stable.
- R with RID=5 while no entry is live → dropped, unexp_rsp=1 until reset.
- Reset asserted with 3 outstanding → count=0, rsp_vld=0. A subsequent stale B is dropped and unexp_rsp is set.
